// File: rtl/interrupt_seq.sv
// interrupt_seq: reset/NMI/IRQ/BRK push and vector-fetch sequencer for the 6502 core
module interrupt_seq #(
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] RST_VEC = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        rdy,
  input  logic        nmi_b,
  input  logic        irq_b,
  input  logic        i_flag,
  input  logic        last_cycle,
  input  logic        brk_start,
  output logic        busy,
  output logic        take_int,
  output logic        stack_wr,
  output logic        stack_dec,
  output logic [1:0]  push_sel,
  output logic        b_flag,
  output logic        vec_rd,
  output logic [15:0] vec_addr,
  output logic        pcl_load,
  output logic        pch_load,
  output logic        set_i,
  output logic        done
);
  typedef enum logic [3:0] {
    RST_HOLD, RST_D1, RST_D2, RST_D3, IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI
  } state_t;
  state_t state;
  logic nmi_q, nmi_pend, brk, push, dummy;
  logic [15:0] base;
  assign take_int = ~reset & rdy & last_cycle & (state == IDLE) & (nmi_pend | (~irq_b & ~i_flag));
  always_ff @(posedge ph1) begin
    if (reset) begin
      state    <= RST_HOLD;
      nmi_q    <= 1'b1;
      nmi_pend <= 1'b0;
      brk      <= 1'b0;
      base     <= RST_VEC;
    end else begin
      nmi_q    <= nmi_b;
      // a new falling edge outranks the clear taken when the NMI vector is latched
      nmi_pend <= (nmi_q & ~nmi_b) | (nmi_pend & ~(rdy & state == PUSH_P));
      if (rdy)
        case (state)
          RST_HOLD: state <= RST_D1;
          RST_D1:   state <= RST_D2;
          RST_D2:   state <= RST_D3;
          RST_D3: begin
            state <= VEC_LO;
            base  <= RST_VEC;
          end
          IDLE:
            if (take_int) begin
              state <= PUSH_PCH;
              brk   <= 1'b0;
            end else if (brk_start) begin
              state <= PUSH_PCH;
              brk   <= 1'b1;
            end
          PUSH_PCH: state <= PUSH_PCL;
          PUSH_PCL: state <= PUSH_P;
          PUSH_P: begin
            state <= VEC_LO;
            base  <= nmi_pend ? NMI_VEC : IRQ_VEC;
          end
          VEC_LO:   state <= VEC_HI;
          VEC_HI: begin
            state <= IDLE;
            brk   <= 1'b0;
          end
          default:  state <= RST_HOLD;
        endcase
    end
  end
  assign push      = state inside {PUSH_PCH, PUSH_PCL, PUSH_P};
  assign dummy     = state inside {RST_D1, RST_D2, RST_D3};
  assign busy      = state != IDLE;
  assign stack_wr  = rdy & push;
  assign stack_dec = rdy & (push | dummy);
  assign push_sel  = state == PUSH_PCL ? 2'b01 : state == PUSH_P ? 2'b10 : 2'b00;
  assign b_flag    = brk;
  assign vec_rd    = state == VEC_LO || state == VEC_HI;
  assign vec_addr  = state == VEC_LO ? base : state == VEC_HI ? base + 16'd1 : RST_VEC;
  assign pcl_load  = rdy & (state == VEC_LO);
  assign set_i     = rdy & (state == VEC_LO);
  assign pch_load  = rdy & (state == VEC_HI);
  assign done      = rdy & (state == VEC_HI);
endmodule
